// File: rtl/prisoner_attempt_sequencer_if.sv
// prisoner_attempt_sequencer_if: command/response bundle between the attempt sequencer and the prisoner responder
interface prisoner_attempt_sequencer_if;
  logic start;
  logic [31:0] cfg_key;
  logic [7:0] cfg_secret;
  logic [7:0] guess_base;
  logic [7:0] guess_step;
  logic [2:0] state_reg;
  logic [7:0] input_data;
  logic [31:0] guard_key;
  logic attempted;
  logic fail;
  logic busy;
  logic done;
  logic success;
  logic timeout_err;
  logic [7:0] attempt_count;
  logic [7:0] found_data;
  modport master (
    input start, cfg_key, cfg_secret, guess_base, guess_step, attempted, fail,
    output state_reg, input_data, guard_key, busy, done, success, timeout_err, attempt_count, found_data
  );
  modport slave (
    output start, cfg_key, cfg_secret, guess_base, guess_step, attempted, fail,
    input state_reg, input_data, guard_key, busy, done, success, timeout_err, attempt_count, found_data
  );
endinterface

// File: rtl/prisoner_attempt_sequencer.sv
// prisoner_attempt_sequencer: drives LOAD then HOLD/ATTEMPT guesses into the prisoner responder until match, exhaustion or timeout
module prisoner_attempt_sequencer #(
  parameter int MAX_ATTEMPTS = 16,
  parameter int HOLD_CYCLES = 1,
  parameter int RESP_TIMEOUT = 4
) (
  input logic clk,
  input logic rst_n,
  prisoner_attempt_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_HOLD = 3'd2, S_ATTEMPT = 3'd3, S_WAIT = 3'd4, S_DONE = 3'd5;
  localparam logic [2:0] C_IDLE = 3'b000, C_LOAD = 3'b001, C_HOLD = 3'b100, C_ATTEMPT = 3'b010;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  logic [2:0] fsm;
  logic [7:0] guess;
  logic [7:0] step;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] wait_cnt;
  logic match;
  logic last;
  logic fin;
  always_comb begin
    match = bus.attempted && !bus.fail;
    last = bus.attempt_count == 8'(MAX_ATTEMPTS);
    fin = fsm == S_WAIT && (bus.attempted ? (match || last) : wait_cnt == TW'(RESP_TIMEOUT - 1));
  end
  // Outputs are loaded on the edge that enters each state, so the command code is visible for that state's whole duration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      guess <= '0;
      step <= '0;
      hold_cnt <= '0;
      wait_cnt <= '0;
      bus.state_reg <= C_IDLE;
      bus.input_data <= '0;
      bus.guard_key <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.success <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.attempt_count <= '0;
      bus.found_data <= '0;
    end else begin
      bus.done <= 1'b0;
      case (fsm)
        S_IDLE: if (bus.start) begin
          fsm <= S_LOAD;
          guess <= bus.guess_base;
          step <= bus.guess_step;
          bus.busy <= 1'b1;
          bus.state_reg <= C_LOAD;
          bus.guard_key <= bus.cfg_key;
          bus.input_data <= bus.cfg_secret;
          bus.success <= 1'b0;
          bus.timeout_err <= 1'b0;
          bus.attempt_count <= '0;
          bus.found_data <= '0;
        end
        S_LOAD: begin
          fsm <= S_HOLD;
          hold_cnt <= '0;
          bus.state_reg <= C_HOLD;
        end
        S_HOLD: if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          fsm <= S_ATTEMPT;
          bus.state_reg <= C_ATTEMPT;
          bus.input_data <= guess;
          bus.attempt_count <= bus.attempt_count + 8'd1;
        end else hold_cnt <= hold_cnt + HW'(1);
        S_ATTEMPT: begin
          fsm <= S_WAIT;
          wait_cnt <= '0;
          bus.state_reg <= C_HOLD;
        end
        S_WAIT: if (fin) begin
          fsm <= S_DONE;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          bus.state_reg <= C_IDLE;
          bus.guard_key <= '0;
          bus.success <= match;
          bus.timeout_err <= !bus.attempted;
          bus.found_data <= match ? guess : 8'h00;
        end else if (bus.attempted) begin
          fsm <= S_HOLD;
          hold_cnt <= '0;
          guess <= guess + step;
        end else wait_cnt <= wait_cnt + TW'(1);
        default: fsm <= S_IDLE;
      endcase
    end
  end
endmodule
